// File: rtl/compute_sequencer_if.sv
// Bundle of the control and address-issue signals between a pass requester
// and the compute sequencer. The sequencer sits on the slave modport.
interface compute_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 2
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // Issue handshake: an address is transferred in every cycle where
    // addr_valid=1. There is no ready; the requester holds issue by raising
    // stall, which drops addr_valid in that same cycle and freezes address.
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  stall;
    logic                  abort;

    logic                  busy;
    logic                  addr_valid;
    logic [ADDR_WIDTH-1:0] address;
    logic                  write_mode;
    logic [BANK_W-1:0]     bank_sel;
    logic                  compute_ready;
    logic                  done;
    logic [1:0]            dbg_state;

    modport master (
        output start, mode, base_addr, count, stall, abort,
        input  busy, addr_valid, address, write_mode, bank_sel,
               compute_ready, done, dbg_state
    );

    modport slave (
        input  start, mode, base_addr, count, stall, abort,
        output busy, addr_valid, address, write_mode, bank_sel,
               compute_ready, done, dbg_state
    );
endinterface

// File: rtl/compute_sequencer.sv
// Issues a run of consecutive BRAM addresses per accepted start, rotating the
// target bank after each completed pass and flagging when compute may begin.
module compute_sequencer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_BANKS    = 2,
    parameter int ARM_DELAY    = 2,
    parameter int READY_OFFSET = 1
) (
    input logic                    clk,
    input logic                    reset,
    compute_sequencer_if.slave     bus
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ARM_W  = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = (ADDR_WIDTH)'(1);
    localparam logic [ARM_W-1:0]      ARM_ONE  = (ARM_W)'(1);
    localparam logic [ARM_W-1:0]      ARM_INIT = (ARM_W)'(ARM_DELAY - 1);
    localparam logic [BANK_W-1:0]     BANK_ONE = (BANK_W)'(1);
    localparam logic [BANK_W-1:0]     BANK_MAX = (BANK_W)'(NUM_BANKS - 1);
    localparam logic [31:0]           RDY_OFF  = 32'(READY_OFFSET);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mode_q;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   offset_q;
    logic [ARM_W-1:0]      arm_cnt_q;
    logic [BANK_W-1:0]     bank_q;

    logic                  issue;
    logic                  last_issue;
    logic [31:0]           offset_ext;
    logic [31:0]           count_ext;

    // An address goes out in every RUN cycle that is neither stalled nor aborted.
    assign issue      = (state_q == S_RUN) && !bus.stall && !bus.abort;
    assign last_issue = (offset_q == (count_q - CNT_ONE));
    assign offset_ext = 32'(offset_q);
    assign count_ext  = 32'(count_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
            ready_q   <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            offset_q  <= '0;
            arm_cnt_q <= '0;
            bank_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort && (state_q != S_IDLE)) begin
                // Abandon the pass: no done, bank unchanged, readiness withdrawn.
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                mode_q   <= 1'b0;
                ready_q  <= 1'b0;
                addr_q   <= '0;
                offset_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && (bus.count != '0)) begin
                            state_q   <= S_ARM;
                            busy_q    <= 1'b1;
                            mode_q    <= bus.mode;
                            addr_q    <= bus.base_addr;
                            count_q   <= bus.count;
                            offset_q  <= '0;
                            ready_q   <= 1'b0;
                            arm_cnt_q <= ARM_INIT;
                        end
                    end
                    S_ARM: begin
                        if (arm_cnt_q == '0) begin
                            state_q <= S_RUN;
                        end else begin
                            arm_cnt_q <= arm_cnt_q - ARM_ONE;
                        end
                    end
                    S_RUN: begin
                        if (!bus.stall) begin
                            offset_q <= offset_q + CNT_ONE;
                            addr_q   <= addr_q + ADDR_ONE;
                            if (offset_ext == RDY_OFF) begin
                                ready_q <= 1'b1;
                            end
                            if (last_issue) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                // Short passes never reach the ready offset.
                                if (count_ext <= RDY_OFF) begin
                                    ready_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        mode_q   <= 1'b0;
                        addr_q   <= '0;
                        offset_q <= '0;
                        bank_q   <= (bank_q == BANK_MAX) ? '0 : bank_q + BANK_ONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.addr_valid    = issue;
    assign bus.address       = addr_q;
    assign bus.write_mode    = mode_q;
    assign bus.bank_sel      = bank_q;
    assign bus.compute_ready = ready_q;
    assign bus.done          = done_q && !bus.abort;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_compute_sequencer.sv
// Bench for compute_sequencer: directed passes plus random passes with random
// stall/abort, checked against a pass-level expectation model.
module tb_compute_sequencer;
    localparam int AW  = 4;
    localparam int NB  = 2;
    localparam int ARM = 2;
    localparam int RDY = 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   exp_bank;
    logic [AW-1:0] exp_q[$];

    compute_sequencer_if #(.ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

    compute_sequencer #(
        .ADDR_WIDTH(AW), .NUM_BANKS(NB), .ARM_DELAY(ARM), .READY_OFFSET(RDY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag, input int bank, input logic rdy);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_valid"}, 32'(bus.addr_valid), 32'd0);
        check({tag, "_wmode"}, 32'(bus.write_mode), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_bank"},  32'(bus.bank_sel), 32'(bank));
        check({tag, "_ready"}, 32'(bus.compute_ready), 32'(rdy));
    endtask

    // One pass from the requester's view. stall_at/stall_len force a stall run
    // once stall_at addresses have gone out; abort_k is the cycle (counted from
    // the start-sampling edge) carrying abort, 0 for none.
    task automatic run_pass(input logic m, input logic [AW-1:0] b, input logic [AW:0] c,
                            input int stall_pct, input int stall_at, input int stall_len,
                            input int abort_k);
        int   k;
        int   issued;
        int   stalled;
        logic stall_now;
        logic abort_now;
        logic in_run;
        logic in_done;
        logic aborted;
        logic exp_rdy;
        bit   fin;
        exp_q.delete();
        for (int i = 0; i < int'(c); i++) exp_q.push_back(AW'(int'(b) + i));
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.base_addr = b; bus.count = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mode = 1'($urandom);
        bus.base_addr = AW'($urandom);
        bus.count = (AW+1)'($urandom_range(1, 16));
        if (c == '0) begin
            @(negedge clk);
            check("zero_cnt_busy", 32'(bus.busy), 32'd0);
            check("zero_cnt_bank", 32'(bus.bank_sel), 32'(exp_bank));
            return;
        end
        k = 0; issued = 0; stalled = 0; fin = 0; aborted = 0;
        while (!fin) begin
            k++;
            in_run    = (k > ARM) && (issued < int'(c));
            in_done   = (issued == int'(c));
            abort_now = (k == abort_k);
            stall_now = ($urandom_range(0, 99) < stall_pct);
            if (in_run && issued == stall_at && stalled < stall_len) begin
                stall_now = 1'b1;
                stalled++;
            end
            bus.stall = stall_now; bus.abort = abort_now;
            exp_rdy = in_done || (issued > RDY);
            @(negedge clk);
            check("pass_busy",  32'(bus.busy), 32'd1);
            check("pass_wmode", 32'(bus.write_mode), 32'(m));
            check("pass_ready", 32'(bus.compute_ready), 32'(exp_rdy));
            if (abort_now) begin
                check("abort_valid", 32'(bus.addr_valid), 32'd0);
                check("abort_done",  32'(bus.done), 32'd0);
                aborted = 1; fin = 1;
            end else if (in_done) begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("done_valid", 32'(bus.addr_valid), 32'd0);
                exp_bank = (exp_bank + 1) % NB;
                fin = 1;
            end else begin
                check("run_done", 32'(bus.done), 32'd0);
                if (in_run && !stall_now) begin
                    check("issue_valid", 32'(bus.addr_valid), 32'd1);
                    check("issue_addr",  32'(bus.address), 32'(exp_q.pop_front()));
                    issued++;
                end else begin
                    check("hold_valid", 32'(bus.addr_valid), 32'd0);
                end
            end
            if (k > 500) begin
                check("pass_timeout", 32'(k), 32'd500);
                fin = 1;
            end
            @(posedge clk); #1;
        end
        bus.stall = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        check_idle("post", exp_bank, !aborted);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; exp_bank = 0;
        bus.start = 0; bus.mode = 0; bus.base_addr = '0; bus.count = '0;
        bus.stall = 0; bus.abort = 0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset", 0, 1'b0);
        check("reset_addr", 32'(bus.address), 32'd0);
        @(negedge clk); reset = 1'b1;

        // Start in IDLE with abort held is unaffected by the abort.
        bus.abort = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        bus.abort = 1'b0;

        run_pass(1'b0, 4'd3,  5'd4, 0, -1, 0, 0);   // 3,4,5,6 bank 0->1
        run_pass(1'b1, 4'd14, 5'd4, 0, -1, 0, 0);   // wraps 14,15,0,1
        run_pass(1'b0, 4'd7,  5'd5, 0, 2, 2, 0);    // two stall cycles after 2nd address
        run_pass(1'b1, 4'd9,  5'd6, 0, -1, 0, ARM + 3);  // abort after two addresses
        run_pass(1'b0, 4'd0,  5'd1, 0, -1, 0, 0);   // count below ready offset
        run_pass(1'b0, 4'd5,  5'd16, 0, -1, 0, 0);  // full address space
        run_pass(1'b0, 4'd2,  5'd0, 0, -1, 0, 0);   // ignored
        run_pass(1'b1, 4'd1,  5'd3, 0, -1, 0, ARM + 4);  // abort in DONE cycle
        run_pass(1'b0, 4'd8,  5'd2, 50, -1, 0, 1);  // abort during ARM

        // Asynchronous reset mid-RUN, checked between clock edges.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.base_addr = 4'd5; bus.count = 5'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_idle("async_rst", 0, 1'b0);
        check("async_rst_addr", 32'(bus.address), 32'd0);
        exp_bank = 0;
        @(negedge clk); reset = 1'b1;
        run_pass(1'b0, 4'd11, 5'd3, 0, -1, 0, 0);

        for (int p = 0; p < 24; p++) begin
            logic [AW:0] c;
            int ab;
            c  = ($urandom_range(0, 9) == 0) ? '0 : (AW+1)'($urandom_range(1, 16));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ARM + int'(c) + 1) : 0;
            run_pass(1'($urandom), AW'($urandom), c, 30,
                     $urandom_range(0, 4), $urandom_range(0, 3), ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/compute_sequencer.md
COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: BRAM address width in bits.
REQ-002 Parameter NUM_BANKS, default 2: number of BRAM banks rotated per pass (>=1).
REQ-003 Parameter ARM_DELAY, default 2: cycles between start acceptance and first issued address (>=1).
REQ-004 Parameter READY_OFFSET, default 1: pass offset at which compute_ready asserts.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 reset  in  1  asynchronous, active-low reset: reset=0 clears all state immediately, independent of clk.
REQ-007 start  in  1  request a pass; sampled only in IDLE.
REQ-008 mode  in  1  0 = read pass, 1 = write pass; captured on start.
REQ-009 base_addr  in  ADDR_WIDTH  first address of pass; captured on start.
REQ-010 count  in  ADDR_WIDTH+1  addresses in pass, 1..2^ADDR_WIDTH; captured on start.
REQ-011 stall  in  1  hold issue for this cycle.
REQ-012 abort  in  1  terminate current pass.
REQ-013 busy  out  1  high in ARM, RUN, DONE.
REQ-014 addr_valid  out  1  address/write_mode valid this cycle.
REQ-015 address  out  ADDR_WIDTH  BRAM address.
REQ-016 write_mode  out  1  0 = read, 1 = write; equals captured mode while busy, 0 otherwise.
REQ-017 bank_sel  out  max(1,$clog2(NUM_BANKS))  bank targeted by current pass.
REQ-018 compute_ready  out  1  downstream compute may begin; sticky until next accepted start.
REQ-019 done  out  1  one-cycle pulse on normal pass completion.

Function
REQ-020 The FSM SHALL have states IDLE, ARM, RUN, DONE.
REQ-021 IDLE: start=1 and count!=0 -> capture mode/base_addr/count, clear offset and compute_ready, go ARM; start with count=0 -> ignored, stay IDLE.
REQ-022 ARM: hold exactly ARM_DELAY cycles (addr_valid=0), then RUN; first addr_valid therefore ARM_DELAY+1 cycles after the start-sampling edge (barring stall).
REQ-023 RUN, stall=0: addr_valid=1, address=(base+offset) mod 2^ADDR_WIDTH, offset increments.
REQ-024 RUN, stall=1: addr_valid=0, address and offset held.
REQ-025 Address SHALL wrap from 2^ADDR_WIDTH-1 to 0 within a pass without error.
REQ-026 Issuing offset count-1 ends RUN; next state DONE.
REQ-027 DONE: done=1 for one cycle, addr_valid=0, bank_sel advances by 1 (NUM_BANKS-1 wraps to 0), return to IDLE; start in DONE is ignored.
REQ-028 compute_ready SHALL go high the cycle after offset READY_OFFSET is issued; if count<=READY_OFFSET, high in DONE cycle.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle: no done, bank_sel unchanged, compute_ready cleared, addr_valid=0 in that cycle.
REQ-030 abort has priority over stall; stall is ignored outside RUN; abort in IDLE has no effect.
REQ-031 Inputs mode/base_addr/count changing after capture SHALL not affect the running pass.

Reset
REQ-032 On reset=0: state IDLE, busy=0, addr_valid=0, address=0, write_mode=0, bank_sel=0, compute_ready=0, done=0, offset=0.
REQ-033 Reset asserted mid-pass SHALL abandon the pass with no done pulse; first start after release behaves as from power-up.

Verification
REQ-034 ADDR_WIDTH=4, start with base=3,count=4,mode=0 -> two ARM cycles, then addresses 3,4,5,6 with addr_valid, compute_ready high after 4, done pulse, bank_sel 0->1.
REQ-035 base=14,count=4,mode=1 -> addresses 14,15,0,1, write_mode=1 throughout, done pulse.
REQ-036 count=5, stall high for 2 cycles after second address -> address held, addr_valid low 2 cycles, pass completes 2 cycles later with same sequence.
REQ-037 abort during RUN after 2 addresses -> IDLE next cycle, no done, compute_ready=0, bank_sel unchanged.
REQ-038 Three back-to-back passes, NUM_BANKS=2 -> bank_sel 0,1,0; start with count=0 -> no busy.
REQ-039 reset pulsed low asynchronously mid-RUN -> all outputs to REQ-032 values without clock edge; next start works normally.
